// File: rtl/guess_engine.sv
// Number-guessing engine: free-running LFSR supplies the secret, FSM scores guesses.
// Optional macro GUESS_HINT_EN enables the red (too high) / blue (too low) hint LEDs.
module guess_engine #(
  parameter int               WIDTH     = 4,
  parameter int               MAX_TRIES = 8,
  parameter logic [WIDTH-1:0] SEED      = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             new_game,
  input  logic [WIDTH-1:0] guess,
  input  logic             guess_valid,
  output logic             led_red,
  output logic             led_green,
  output logic             led_blue,
  output logic [7:0]       tries_left,
  output logic             win,
  output logic             lose,
  output logic [WIDTH-1:0] secret_out
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LFSR_INIT = (SEED == '0) ? ONE : SEED;
  localparam logic [7:0]       TRY_INIT  = MAX_TRIES[7:0];
  // Maximal-length tap masks, one bit per zero-based tap position.
  localparam logic [7:0] TAPS = (WIDTH == 4) ? 8'b0000_1100 :
                                (WIDTH == 5) ? 8'b0001_0100 :
                                (WIDTH == 6) ? 8'b0011_0000 :
                                (WIDTH == 7) ? 8'b0110_0000 :
                                               8'b1011_1000;

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, r_secret;
  logic [7:0]       r_tries;
  logic             r_red, r_green, r_blue;
  logic             w_fb, w_accept, w_gt, w_eq, w_lt;
  logic [WIDTH-1:0] w_lfsr_nxt, w_draw;

  assign w_fb       = ^(r_lfsr & TAPS[WIDTH-1:0]);
  // An all-zero register would lock up; recover to the seed instead.
  assign w_lfsr_nxt = (r_lfsr == '0) ? LFSR_INIT : {r_lfsr[WIDTH-2:0], w_fb};
  assign w_draw     = (r_lfsr == '0) ? LFSR_INIT : r_lfsr;

  assign w_accept = guess_valid && (r_state == PLAY) && !new_game;
  assign w_eq     = (guess == r_secret);
`ifdef GUESS_HINT_EN
  assign w_gt     = (guess >  r_secret);
  assign w_lt     = (guess <  r_secret);
`else
  assign w_gt     = 1'b0;
  assign w_lt     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= LFSR_INIT;
    else          r_lfsr <= w_lfsr_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = PLAY;
    end else if (w_accept) begin
      if (w_eq)              w_state_nxt = WIN;
      else if (r_tries == 8'd1) w_state_nxt = LOSE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_secret <= '0;
      r_tries  <= '0;
      r_red    <= 1'b0;
      r_green  <= 1'b0;
      r_blue   <= 1'b0;
    end else if (new_game) begin
      r_secret <= w_draw;
      r_tries  <= TRY_INIT;
      r_red    <= 1'b0;
      r_green  <= 1'b0;
      r_blue   <= 1'b0;
    end else if (w_accept) begin
      r_tries  <= r_tries - 8'd1;
      r_red    <= w_gt;
      r_green  <= w_eq;
      r_blue   <= w_lt;
    end
  end

  assign led_red    = r_red;
  assign led_green  = r_green;
  assign led_blue   = r_blue;
  assign tries_left = r_tries;
  assign win        = (r_state == WIN);
  assign lose       = (r_state == LOSE);
  assign secret_out = (r_state == WIN || r_state == LOSE) ? r_secret : '0;

endmodule

// File: tb/tb_guess_engine.sv
// Directed bench for guess_engine (WIDTH=4, SEED=2, MAX_TRIES=3); hint expectations follow GUESS_HINT_EN.
module tb_guess_engine;
`ifdef GUESS_HINT_EN
  localparam bit HINT = 1'b1;
`else
  localparam bit HINT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, new_game, guess_valid;
  logic [3:0] guess;
  logic       led_red, led_green, led_blue, win, lose;
  logic [7:0] tries_left;
  logic [3:0] secret_out;
  logic [3:0] m_lfsr, exp_sec;
  int         n_assert = 0, n_fail = 0;

  guess_engine #(.WIDTH(4), .MAX_TRIES(3), .SEED(4'b0010)) dut (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .guess(guess),
    .guess_valid(guess_valid), .led_red(led_red), .led_green(led_green),
    .led_blue(led_blue), .tries_left(tries_left), .win(win), .lose(lose),
    .secret_out(secret_out));

  always #5 clk = ~clk;

  // Reference x^4+x^3+1 sequence from seed 0010, used to predict drawn secrets.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m_lfsr <= 4'b0010;
    else          m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] leds();
    return {5'd0, led_red, led_green, led_blue};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  task automatic do_guess(input logic [3:0] g);
    guess = g; guess_valid = 1'b1; tick(); guess_valid = 1'b0;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; new_game = 1'b0; guess_valid = 1'b0; guess = '0;
    tick(); tick();
    chk("rst_tries", tries_left, 8'd0);
    chk("rst_leds", leds(), 8'd0);
    chk("rst_wl", {6'd0, win, lose}, 8'd0);
    chk("rst_sec", {4'd0, secret_out}, 8'd0);

    // Win path: secret 2, guesses 5, 1, 2.
    reset_n = 1'b1;
    start();
    chk("ng_tries", tries_left, 8'd3);
    chk("ng_leds", leds(), 8'd0);
    chk("ng_wl", {6'd0, win, lose}, 8'd0);
    chk("ng_sec_hidden", {4'd0, secret_out}, 8'd0);
    do_guess(4'd5);
    chk("w1_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("w1_tries", tries_left, 8'd2);
    do_guess(4'd1);
    chk("w2_leds", leds(), HINT ? 8'b001 : 8'b000);
    chk("w2_tries", tries_left, 8'd1);
    do_guess(4'd2);
    chk("w3_leds", leds(), 8'b010);
    chk("w3_wl", {6'd0, win, lose}, 8'b10);
    chk("w3_tries", tries_left, 8'd0);
    chk("w3_sec", {4'd0, secret_out}, 8'h2);
    do_guess(4'd7);
    chk("win_hold_leds", leds(), 8'b010);
    chk("win_hold_wl", {6'd0, win, lose}, 8'b10);

    // Lose path: same secret, three wrong guesses.
    hard_reset();
    start();
    do_guess(4'd5);
    chk("l1_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("l1_lose", {7'd0, lose}, 8'd0);
    do_guess(4'd5);
    chk("l2_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("l2_tries", tries_left, 8'd1);
    do_guess(4'd5);
    chk("l3_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("l3_wl", {6'd0, win, lose}, 8'b01);
    chk("l3_tries", tries_left, 8'd0);
    chk("l3_sec", {4'd0, secret_out}, 8'h2);
    do_guess(4'd2);
    chk("lose_hold_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("lose_hold_wl", {6'd0, win, lose}, 8'b01);
    chk("lose_hold_tries", tries_left, 8'd0);

    // New game from LOSE, one guess, then new_game colliding with a guess.
    start();
    chk("relaunch_tries", tries_left, 8'd3);
    do_guess(4'd1);
    exp_sec = m_lfsr;
    new_game = 1'b1; guess = 4'd2; guess_valid = 1'b1;
    tick();
    new_game = 1'b0; guess_valid = 1'b0;
    chk("coll_tries", tries_left, 8'd3);
    chk("coll_leds", leds(), 8'd0);
    chk("coll_wl", {6'd0, win, lose}, 8'd0);
    do_guess(exp_sec);
    chk("coll_win", {6'd0, win, lose}, 8'b10);
    chk("coll_sec", {4'd0, secret_out}, {4'd0, exp_sec});
    chk("coll_green", leds(), 8'b010);

    // Asynchronous reset mid-game, checked before any further edge.
    start();
    do_guess(4'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tries", tries_left, 8'd0);
    chk("arst_leds", leds(), 8'd0);
    chk("arst_wl", {6'd0, win, lose}, 8'd0);
    chk("arst_sec", {4'd0, secret_out}, 8'd0);

    // Single too-high guess against secret 2.
    tick();
    reset_n = 1'b1;
    start();
    do_guess(4'd5);
    chk("hint_leds", leds(), HINT ? 8'b100 : 8'b000);
    chk("hint_tries", tries_left, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/guess_engine.md
GUESS_ENGINE -- requirements
Module: guess_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bit width of secret and guess (legal 4..8).
REQ-002 SHALL have parameter MAX_TRIES, default 8, meaning guesses allowed per game (legal 1..255).
REQ-003 SHALL have parameter SEED, default 1, meaning LFSR reset value (WIDTH bits; 0 is replaced by 1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port new_game  input  1  one-cycle pulse: draw a new secret and start a game.
REQ-007 SHALL have port guess  input  WIDTH  guess value, sampled only with guess_valid.
REQ-008 SHALL have port guess_valid  input  1  one-cycle guess strobe.
REQ-009 SHALL have port led_red  output  1  last guess > secret.
REQ-010 SHALL have port led_green  output  1  last guess == secret.
REQ-011 SHALL have port led_blue  output  1  last guess < secret.
REQ-012 SHALL have port tries_left  output  8  guesses remaining.
REQ-013 SHALL have port win  output  1  high in state WIN.
REQ-014 SHALL have port lose  output  1  high in state LOSE.
REQ-015 SHALL have port secret_out  output  WIDTH  secret reveal; zero unless in WIN or LOSE.

Function
REQ-016 SHALL run a Fibonacci LFSR every cycle in every state, shifting left with feedback into bit 0; taps: 4:{3,2} 5:{4,2} 6:{5,4} 7:{6,5} 8:{7,5,4,3} (zero-based XOR).
REQ-017 SHALL hold FSM states IDLE, PLAY, WIN, LOSE.
REQ-018 SHALL, on new_game high at any edge in any state, capture the current LFSR value as secret, load tries_left=MAX_TRIES, clear all LEDs, and enter PLAY next cycle.
REQ-019 SHALL, on guess_valid in PLAY, register all three LEDs from the compare with one-cycle latency and decrement tries_left by 1.
REQ-020 SHALL go PLAY->WIN when guess==secret, else PLAY->LOSE when tries_left==1, else stay in PLAY.
REQ-021 SHALL ignore guess_valid in IDLE, WIN and LOSE; LEDs and tries_left hold.
REQ-022 SHALL give new_game priority when new_game and guess_valid coincide; the guess is discarded.
REQ-023 SHALL hold LEDs at the last compare result until the next accepted guess or new_game.
REQ-024 SHALL never capture a zero secret (LFSR lockup-free), so legal secrets span 1..2^WIDTH-1.
REQ-025 SHALL use unsigned compares; exactly one LED is high after any accepted guess.

Reset
REQ-026 SHALL, with reset_n low, asynchronously force state IDLE, LFSR=SEED (1 if SEED==0), secret=0, tries_left=0, all LEDs/win/lose/secret_out=0.
REQ-027 SHALL abandon any game in progress when reset_n is asserted mid-game.

Configuration
REQ-028 SHALL honour macro GUESS_HINT_EN: defined -> red/blue hints per REQ-019; undefined -> led_red and led_blue tied 0, only led_green reports.

Verification (WIDTH=4, SEED=4'b0010, MAX_TRIES=3, GUESS_HINT_EN defined)
REQ-029 SHALL check: release reset, new_game at the first edge -> secret=0x2, state PLAY, tries_left=3, LEDs 000.
REQ-030 SHALL check: guesses 5, 1, 2 -> red; blue; green, win=1, tries_left=0, secret_out=0x2.
REQ-031 SHALL check: guesses 5, 5, 5 -> red each time, lose=1 after the third, tries_left=0, a further guess_valid changes nothing.
REQ-032 SHALL check: new_game and guess_valid(guess=2) in the same cycle during PLAY -> new secret captured, tries_left=3, LEDs 000.
REQ-033 SHALL check: reset_n low mid-game after one guess -> all outputs 0 immediately, without a clock edge.
REQ-034 SHALL check: GUESS_HINT_EN undefined, guess 5 vs secret 0x2 -> LEDs 000, tries_left=2.
